axi_lite_arbiter: RTL and testbench
===================================

# axi_lite_arbiter

Two-master to one-slave AXI-lite arbiter that sits directly upstream of the data SRAM. It multiplexes instruction fetch (master 0, IFU) and load/store (master 1, LSU) onto the single SRAM port. One whole transaction is granted at a time: a read ends on the R handshake, a write ends on the B handshake. Arbitration between masters is round-robin.

## Interface
- No parameters; address and data are 32 bits, resp is 1 bit, strobe is 4 bits.
- clk  in  1  system clock, all state on posedge.
- rst  in  1  reset, asynchronous and active-high.
- m0_araddr, m1_araddr  in  32  read address per master.
- m0_arvalid, m1_arvalid  in  1; m0_arready, m1_arready  out  1.
- m0_rdata, m1_rdata  out  32; m0_rresp, m1_rresp  out  1; m0_rvalid, m1_rvalid  out  1; m0_rready, m1_rready  in  1.
- m0_awaddr, m1_awaddr  in  32; m0_awvalid, m1_awvalid  in  1; m0_awready, m1_awready  out  1.
- m0_wdata, m1_wdata  in  32; m0_wstrb, m1_wstrb  in  4; m0_wvalid, m1_wvalid  in  1; m0_wready, m1_wready  out  1.
- m0_bresp, m1_bresp  out  1; m0_bvalid, m1_bvalid  out  1; m0_bready, m1_bready  in  1.
- s_araddr  out  32; s_arvalid  out  1; s_arready  in  1; s_rdata  in  32; s_rresp  in  1; s_rvalid  in  1; s_rready  out  1.
- s_awaddr  out  32; s_awvalid  out  1; s_awready  in  1; s_wdata  out  32; s_wstrb  out  4; s_wvalid  out  1; s_wready  in  1.
- s_bresp  in  1; s_bvalid  in  1; s_bready  out  1.

## Operation
- State register: IDLE, RD, WR. Also registered: grant (0/1) and last (0/1).
- Request of master i: req_i = mi_arvalid | mi_awvalid | mi_wvalid.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one master requests, grant it.
  - If both request, grant the master != last.
  - Granted master goes to WR if its awvalid | wvalid is set, else RD. Within one master, write wins over read.
  - On grant, update last <= grant.
- RD / WR: pure combinational pass-through between the granted master and the slave, on all channels of the active direction.
  - Slave outputs carry the granted master's araddr/awaddr/wdata/wstrb and valids.
  - Granted master's readies are driven from s_arready / s_awready / s_wready.
  - Granted master's rvalid / bvalid are driven from s_rvalid / s_bvalid.
  - s_rready / s_bready are driven from the granted master's rready / bready.
  - Inactive direction: valids and readies are forced 0.
- Non-granted master: every ready and every valid output is 0.
- rdata/rresp/bresp are broadcast to both masters unmasked; only the valids are gated.
- Transaction end:
  - RD -> IDLE on s_rvalid & s_rready.
  - WR -> IDLE on s_bvalid & s_bready.
- IDLE outputs:
  - All s_* valids, s_rready and s_bready are 0.
  - All mi_* readies and valids are 0.
  - s_araddr, s_awaddr, s_wdata and s_wstrb are 0.
- Reset (async, any time, including mid-transaction):
  - state = IDLE, grant = 0, last = 1, so m0 wins the first tie.
  - All outputs take their IDLE values immediately.
  - An in-flight slave transaction is abandoned; no response is forwarded.
- Write channel order: AW and W may handshake in either order or in the same cycle. The arbiter imposes no ordering and stays in WR until B.

## Timing
- Grant costs exactly 1 cycle: a request seen in IDLE at edge N makes the pass-through active from cycle N+1.
- After the end handshake at edge M, state is IDLE in cycle M+1. The earliest next pass-through is cycle M+2, so there is 1 dead cycle between back-to-back transactions.
- There are no combinational paths from mi_*valid to mi_*ready while in IDLE. Readies are functions of state and the slave readies only.
- Starvation bound: with both masters requesting continuously, grants strictly alternate.

## Test plan
- Single read: m0_arvalid with araddr=0x80000000 in IDLE.
  - s_arvalid rises 1 cycle later.
  - Slave returns rdata=0x00000413; m0_rvalid=1 and m0_rdata=0x00000413.
  - m1_rvalid stays 0; state returns to IDLE after the R handshake.
- Single write: m1 presents awaddr=0x80001000, wdata=0xDEADBEEF, wstrb=0xF.
  - Slave sees the same values with s_awvalid=s_wvalid=1.
  - m1_bvalid pulses on s_bvalid; m0_* readies stay 0 throughout.
- Tie after reset: both masters assert arvalid in the same cycle.
  - m0 is served first, then m1.
  - A third simultaneous tie is granted to m0: strict alternation.
- Slave stall: m0 read with s_rvalid held 0 for 5 cycles and m1 requesting meanwhile.
  - m1_arready stays 0 for all 5 cycles.
  - m1 is granted the cycle after the R handshake plus 1.
- Master back-pressure: m1 holds rready=0 for 3 cycles after s_rvalid=1.
  - s_rready=0 for those cycles and state stays RD.
  - IDLE follows the cycle after rready rises.
- Async reset mid-write: assert rst while in WR before B.
  - s_awvalid, s_wvalid and s_bready drop to 0 in the same cycle.
  - After release, the first request is granted as from reset, with m0 winning a tie.

Source files
------------

// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI-lite arbiter in front of the data SRAM.
// Master 0 is the instruction fetch unit, master 1 the load/store unit.
// One whole transaction (read up to R, write up to B) owns the slave port
// at a time; ties between masters are broken round-robin.
module axi_lite_arbiter (
  input  logic        clk,
  input  logic        rst,
  // master 0 read channels
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic        m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  // master 0 write channels
  input  logic [31:0] m0_awaddr,
  input  logic        m0_awvalid,
  output logic        m0_awready,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_wvalid,
  output logic        m0_wready,
  output logic        m0_bresp,
  output logic        m0_bvalid,
  input  logic        m0_bready,
  // master 1 read channels
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic        m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  // master 1 write channels
  input  logic [31:0] m1_awaddr,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic        m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  // slave read channels
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic        s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  // slave write channels
  output logic [31:0] s_awaddr,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic        s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t state, state_next;
  logic   grant, grant_next;
  logic   last, last_next;

  // Granted master's inputs, selected by the registered grant.
  logic [31:0] g_araddr, g_awaddr, g_wdata;
  logic [3:0]  g_wstrb;
  logic        g_arvalid, g_awvalid, g_wvalid, g_rready, g_bready;

  assign g_araddr  = grant ? m1_araddr  : m0_araddr;
  assign g_arvalid = grant ? m1_arvalid : m0_arvalid;
  assign g_rready  = grant ? m1_rready  : m0_rready;
  assign g_awaddr  = grant ? m1_awaddr  : m0_awaddr;
  assign g_awvalid = grant ? m1_awvalid : m0_awvalid;
  assign g_wdata   = grant ? m1_wdata   : m0_wdata;
  assign g_wstrb   = grant ? m1_wstrb   : m0_wstrb;
  assign g_wvalid  = grant ? m1_wvalid  : m0_wvalid;
  assign g_bready  = grant ? m1_bready  : m0_bready;

  // State, grant and round-robin history; reset leaves m0 as the tie winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      grant <= grant_next;
      last  <= last_next;
    end
  end

  // Arbitration in IDLE and end-of-transaction detection in RD/WR.
  always_comb begin
    logic req0, req1, pick, pick_wr;
    state_next = state;
    grant_next = grant;
    last_next  = last;
    req0       = m0_arvalid | m0_awvalid | m0_wvalid;
    req1       = m1_arvalid | m1_awvalid | m1_wvalid;
    pick       = 1'b0;
    pick_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          pick = ~last;
        end else if (req1) begin
          pick = 1'b1;
        end else begin
          pick = 1'b0;
        end
        // Within one master a pending write takes precedence over a read.
        pick_wr = pick ? (m1_awvalid | m1_wvalid) : (m0_awvalid | m0_wvalid);
        if (req0 || req1) begin
          grant_next = pick;
          last_next  = pick;
          state_next = pick_wr ? WR : RD;
        end else begin
          state_next = IDLE;
        end
      end
      RD: begin
        if (s_rvalid && g_rready) begin
          state_next = IDLE;
        end else begin
          state_next = RD;
        end
      end
      WR: begin
        if (s_bvalid && g_bready) begin
          state_next = IDLE;
        end else begin
          state_next = WR;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pass-through of the active direction; everything else is held at 0.
  always_comb begin
    s_araddr   = 32'h0000_0000;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = 32'h0000_0000;
    s_awvalid  = 1'b0;
    s_wdata    = 32'h0000_0000;
    s_wstrb    = 4'h0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_awready = 1'b0;
    m0_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    // Response payloads go to both masters; only the valids are steered.
    m0_rdata   = s_rdata;
    m0_rresp   = s_rresp;
    m0_bresp   = s_bresp;
    m1_rdata   = s_rdata;
    m1_rresp   = s_rresp;
    m1_bresp   = s_bresp;
    case (state)
      RD: begin
        s_araddr  = g_araddr;
        s_arvalid = g_arvalid;
        s_rready  = g_rready;
        if (grant) begin
          m1_arready = s_arready;
          m1_rvalid  = s_rvalid;
        end else begin
          m0_arready = s_arready;
          m0_rvalid  = s_rvalid;
        end
      end
      WR: begin
        s_awaddr  = g_awaddr;
        s_awvalid = g_awvalid;
        s_wdata   = g_wdata;
        s_wstrb   = g_wstrb;
        s_wvalid  = g_wvalid;
        s_bready  = g_bready;
        if (grant) begin
          m1_awready = s_awready;
          m1_wready  = s_wready;
          m1_bvalid  = s_bvalid;
        end else begin
          m0_awready = s_awready;
          m0_wready  = s_wready;
          m0_bvalid  = s_bvalid;
        end
      end
      default: begin
        s_arvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: directed scenarios with literal
// expectations, then random traffic checked every cycle against a
// transaction-level model (who owns the slave, which direction, who went last).
module tb_axi_lite_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // master-side inputs, index = master number
  logic [1:0]       arvalid, rready, awvalid, wvalid, bready;
  logic [1:0][31:0] araddr, awaddr, wdata;
  logic [1:0][3:0]  wstrb;
  // slave-side inputs
  logic [31:0] s_rdata;
  logic        s_arready, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid;

  wire        m0_arready, m0_rresp, m0_rvalid, m0_awready, m0_wready, m0_bresp, m0_bvalid;
  wire        m1_arready, m1_rresp, m1_rvalid, m1_awready, m1_wready, m1_bresp, m1_bvalid;
  wire [31:0] m0_rdata, m1_rdata;
  wire [31:0] s_araddr, s_awaddr, s_wdata;
  wire [3:0]  s_wstrb;
  wire        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;

  axi_lite_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(rready[0]),
    .m0_awaddr(awaddr[0]), .m0_awvalid(awvalid[0]), .m0_awready(m0_awready),
    .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wvalid(wvalid[0]), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(bready[0]),
    .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(rready[1]),
    .m1_awaddr(awaddr[1]), .m1_awvalid(awvalid[1]), .m1_awready(m1_awready),
    .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wvalid(wvalid[1]), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(bready[1]),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit m_busy  = 1'b0;   // a transaction currently owns the slave
  int m_owner = 0;      // which master owns it
  bit m_wr    = 1'b0;   // owning transaction is a write
  int m_last  = 1;      // master granted most recently

  // Model update: round-robin pick when free, release on R/B handshake.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_wr = 1'b0; m_last = 1;
    end else if (!m_busy) begin
      bit r0, r1;
      r0 = arvalid[0] | awvalid[0] | wvalid[0];
      r1 = arvalid[1] | awvalid[1] | wvalid[1];
      if (r0 || r1) begin
        if (r0 && r1) m_owner = 1 - m_last;
        else          m_owner = r1 ? 1 : 0;
        m_wr   = awvalid[m_owner] | wvalid[m_owner];
        m_busy = 1'b1;
        m_last = m_owner;
      end
    end else begin
      if (m_wr ? (s_bvalid && bready[m_owner]) : (s_rvalid && rready[m_owner]))
        m_busy = 1'b0;
    end
  end

  wire [1:0]  arready_o = {m1_arready, m0_arready};
  wire [1:0]  rvalid_o  = {m1_rvalid,  m0_rvalid};
  wire [1:0]  awready_o = {m1_awready, m0_awready};
  wire [1:0]  wready_o  = {m1_wready,  m0_wready};
  wire [1:0]  bvalid_o  = {m1_bvalid,  m0_bvalid};
  wire [1:0]  rresp_o   = {m1_rresp,   m0_rresp};
  wire [1:0]  bresp_o   = {m1_bresp,   m0_bresp};
  wire [63:0] rdata_o   = {m1_rdata,   m0_rdata};

  bit rd_on, wr_on;

  // Compare process: every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      rd_on = m_busy && !m_wr;
      wr_on = m_busy && m_wr;
      chk("s_arvalid", {31'd0, s_arvalid}, {31'd0, rd_on && arvalid[m_owner]});
      chk("s_rready",  {31'd0, s_rready},  {31'd0, rd_on && rready[m_owner]});
      chk("s_awvalid", {31'd0, s_awvalid}, {31'd0, wr_on && awvalid[m_owner]});
      chk("s_wvalid",  {31'd0, s_wvalid},  {31'd0, wr_on && wvalid[m_owner]});
      chk("s_bready",  {31'd0, s_bready},  {31'd0, wr_on && bready[m_owner]});
      chk("s_araddr",  s_araddr, rd_on ? araddr[m_owner] : 32'd0);
      chk("s_awaddr",  s_awaddr, wr_on ? awaddr[m_owner] : 32'd0);
      chk("s_wdata",   s_wdata,  wr_on ? wdata[m_owner]  : 32'd0);
      chk("s_wstrb",   {28'd0, s_wstrb}, {28'd0, wr_on ? wstrb[m_owner] : 4'd0});
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m%0d_arready", i), {31'd0, arready_o[i]}, {31'd0, rd_on && m_owner == i && s_arready});
        chk($sformatf("m%0d_rvalid", i),  {31'd0, rvalid_o[i]},  {31'd0, rd_on && m_owner == i && s_rvalid});
        chk($sformatf("m%0d_awready", i), {31'd0, awready_o[i]}, {31'd0, wr_on && m_owner == i && s_awready});
        chk($sformatf("m%0d_wready", i),  {31'd0, wready_o[i]},  {31'd0, wr_on && m_owner == i && s_wready});
        chk($sformatf("m%0d_bvalid", i),  {31'd0, bvalid_o[i]},  {31'd0, wr_on && m_owner == i && s_bvalid});
        chk($sformatf("m%0d_rdata", i),   rdata_o[i*32 +: 32], s_rdata);
        chk($sformatf("m%0d_rresp", i),   {31'd0, rresp_o[i]}, {31'd0, s_rresp});
        chk($sformatf("m%0d_bresp", i),   {31'd0, bresp_o[i]}, {31'd0, s_bresp});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    s_arready = 1'b0; s_rdata = 32'd0; s_rresp = 1'b0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = 1'b0; s_bvalid = 1'b0;
  endtask

  localparam logic [31:0] A0 = 32'h8000_0100;
  localparam logic [31:0] A1 = 32'h8000_0200;

  initial begin
    clr();
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) cyc();
    chk("rst_s_arvalid", {31'd0, s_arvalid}, 32'd0);
    chk("rst_m0_arready", {31'd0, m0_arready}, 32'd0);
    rst = 1'b0;

    // single read from m0
    arvalid[0] = 1'b1; araddr[0] = 32'h8000_0000; s_arready = 1'b1;
    #2 chk("rd_idle_no_arvalid", {31'd0, s_arvalid}, 32'd0);
    chk("rd_idle_no_arready", {31'd0, m0_arready}, 32'd0);
    cyc();
    chk("rd_s_arvalid", {31'd0, s_arvalid}, 32'd1);
    chk("rd_s_araddr", s_araddr, 32'h8000_0000);
    chk("rd_m0_arready", {31'd0, m0_arready}, 32'd1);
    cyc();
    arvalid[0] = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_0413; rready[0] = 1'b1;
    #2 chk("rd_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'h0000_0413);
    chk("rd_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("rd_s_rready", {31'd0, s_rready}, 32'd1);
    cyc();
    #2 chk("rd_back_idle_rready", {31'd0, s_rready}, 32'd0);
    chk("rd_back_idle_rvalid", {31'd0, m0_rvalid}, 32'd0);
    clr();

    // single write from m1
    awvalid[1] = 1'b1; awaddr[1] = 32'h8000_1000; wvalid[1] = 1'b1;
    wdata[1] = 32'hDEAD_BEEF; wstrb[1] = 4'hF; bready[1] = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    cyc();
    #2 chk("wr_s_awvalid", {31'd0, s_awvalid}, 32'd1);
    chk("wr_s_wvalid", {31'd0, s_wvalid}, 32'd1);
    chk("wr_s_awaddr", s_awaddr, 32'h8000_1000);
    chk("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("wr_s_wstrb", {28'd0, s_wstrb}, 32'h0000_000F);
    chk("wr_m1_awready", {31'd0, m1_awready}, 32'd1);
    chk("wr_m0_awready", {31'd0, m0_awready}, 32'd0);
    chk("wr_m0_arready", {31'd0, m0_arready}, 32'd0);
    cyc();
    awvalid[1] = 1'b0; wvalid[1] = 1'b0; s_bvalid = 1'b1;
    #2 chk("wr_m1_bvalid", {31'd0, m1_bvalid}, 32'd1);
    chk("wr_m0_bvalid", {31'd0, m0_bvalid}, 32'd0);
    chk("wr_s_bready", {31'd0, s_bready}, 32'd1);
    cyc();
    clr();

    // ties after reset alternate m0, m1, m0
    rst = 1'b1; cyc(); rst = 1'b0;
    arvalid = 2'b11; araddr[0] = A0; araddr[1] = A1; rready = 2'b11; s_arready = 1'b1;
    cyc();
    #2 chk("tie1_m0", s_araddr, A0);
    arvalid[0] = 1'b0; s_rvalid = 1'b1;
    cyc();
    s_rvalid = 1'b0; arvalid[0] = 1'b1;
    #2 chk("tie_dead_cycle", {31'd0, s_arvalid}, 32'd0);
    cyc();
    #2 chk("tie2_m1", s_araddr, A1);
    arvalid[1] = 1'b0; s_rvalid = 1'b1;
    cyc();
    s_rvalid = 1'b0; arvalid[1] = 1'b1;
    cyc();
    #2 chk("tie3_m0", s_araddr, A0);
    arvalid = 2'b00; s_rvalid = 1'b1;
    cyc();
    s_rvalid = 1'b0;

    // slave stall on m0 read while m1 waits
    arvalid[0] = 1'b1;
    cyc();
    arvalid[0] = 1'b0; arvalid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2 chk("stall_m1_arready", {31'd0, m1_arready}, 32'd0);
      cyc();
    end
    s_rvalid = 1'b1;
    cyc();
    s_rvalid = 1'b0;
    #2 chk("stall_idle_m1_arready", {31'd0, m1_arready}, 32'd0);
    cyc();
    #2 chk("stall_m1_granted", {31'd0, m1_arready}, 32'd1);
    chk("stall_m1_addr", s_araddr, A1);
    arvalid[1] = 1'b0; s_rvalid = 1'b1;
    cyc();
    clr();

    // m1 back-pressures R for 3 cycles
    arvalid[1] = 1'b1; araddr[1] = A1; s_arready = 1'b1;
    cyc();
    arvalid[1] = 1'b0; s_rvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2 chk("bp_s_rready", {31'd0, s_rready}, 32'd0);
      chk("bp_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
      cyc();
    end
    rready[1] = 1'b1;
    #2 chk("bp_release", {31'd0, s_rready}, 32'd1);
    cyc();
    #2 chk("bp_idle_rvalid", {31'd0, m1_rvalid}, 32'd0);
    clr();

    // async reset in the middle of an m0 write
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b1; awaddr[0] = A0;
    cyc();
    #2 chk("ar_s_awvalid_pre", {31'd0, s_awvalid}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("ar_s_awvalid", {31'd0, s_awvalid}, 32'd0);
    chk("ar_s_wvalid", {31'd0, s_wvalid}, 32'd0);
    chk("ar_s_bready", {31'd0, s_bready}, 32'd0);
    clr();
    cyc();
    rst = 1'b0;
    arvalid = 2'b11; araddr[0] = A0; araddr[1] = A1; rready = 2'b11; s_arready = 1'b1;
    cyc();
    #2 chk("ar_tie_m0", s_araddr, A0);
    chk("ar_tie_m0_ready", {31'd0, m0_arready}, 32'd1);
    arvalid = 2'b00; s_rvalid = 1'b1;
    cyc();
    clr();

    // randomized traffic, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 2; i++) begin
        arvalid[i] = ($urandom_range(0, 3) == 0);
        awvalid[i] = ($urandom_range(0, 5) == 0);
        wvalid[i]  = ($urandom_range(0, 5) == 0);
        rready[i]  = $urandom_range(0, 1);
        bready[i]  = $urandom_range(0, 1);
        araddr[i]  = $urandom;
        awaddr[i]  = $urandom;
        wdata[i]   = $urandom;
        wstrb[i]   = 4'($urandom);
      end
      s_arready = $urandom_range(0, 1);
      s_awready = $urandom_range(0, 1);
      s_wready  = $urandom_range(0, 1);
      s_rvalid  = ($urandom_range(0, 2) == 0);
      s_bvalid  = ($urandom_range(0, 2) == 0);
      s_rdata   = $urandom;
      s_rresp   = $urandom_range(0, 1);
      s_bresp   = $urandom_range(0, 1);
    end
    cyc();
    rst = 1'b0;
    clr();
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
